// File: rtl/smart_home_pkg.sv
// Shared types and helpers for the multizone smart-home controller.
// Zone state encoding and the colour sequencer's step function.
package smart_home_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAT = 2'b01,
    COOL = 2'b10
  } zone_state_t;

  localparam logic [2:0] COLOUR_FIRST = 3'b001;
  localparam logic [2:0] COLOUR_LAST  = 3'b110;

  // 000 and 111 are not in the cycle; both recover to the first colour.
  function automatic logic [2:0] next_colour(input logic [2:0] c);
    logic [2:0] n;
    n = COLOUR_FIRST;
    case (c)
      3'b001, 3'b010, 3'b011, 3'b100, 3'b101: n = c + 3'd1;
      COLOUR_LAST:                            n = COLOUR_FIRST;
      default:                                n = COLOUR_FIRST;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/zone_thermostat.sv
// One hysteresis thermostat zone with a minimum-dwell timer in HEAT/COOL.
// state | meaning
// IDLE  | neither heater nor cooler driven; dwell held at 0
// HEAT  | heater on; may leave once warm enough and dwell has saturated
// COOL  | cooler on; may leave once cool enough and dwell has saturated
module zone_thermostat
  import smart_home_pkg::*;
#(
  parameter int TEMP_W    = 5,
  parameter int HEAT_ON   = 18,
  parameter int HEAT_OFF  = 20,
  parameter int COOL_ON   = 22,
  parameter int COOL_OFF  = 20,
  parameter int MIN_DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [TEMP_W-1:0] temp,
  output logic              heating,
  output logic              cooling
);

  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam logic [DW-1:0]     DWELL_MAX  = DW'(MIN_DWELL);
  localparam logic [TEMP_W-1:0] T_HEAT_ON  = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] T_HEAT_OFF = TEMP_W'(HEAT_OFF);
  localparam logic [TEMP_W-1:0] T_COOL_ON  = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] T_COOL_OFF = TEMP_W'(COOL_OFF);

  zone_state_t   state, state_nxt;
  logic [DW-1:0] dwell, dwell_nxt;
  logic          dwell_done;

  assign dwell_done = (dwell == DWELL_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!en)                     state_nxt = IDLE;
        else if (temp <= T_HEAT_ON)  state_nxt = HEAT;
        else if (temp >= T_COOL_ON)  state_nxt = COOL;
        else                         state_nxt = IDLE;
      end
      HEAT: begin
        if (!en || (temp >= T_HEAT_OFF && dwell_done)) state_nxt = IDLE;
      end
      COOL: begin
        if (!en || (temp <= T_COOL_OFF && dwell_done)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Entry into HEAT/COOL always comes from IDLE, where dwell is already 0.
  always_comb begin
    dwell_nxt = '0;
    if (state != IDLE && state_nxt != IDLE)
      dwell_nxt = dwell_done ? dwell : dwell + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      dwell <= '0;
    end else begin
      state <= state_nxt;
      dwell <= dwell_nxt;
    end
  end

  assign heating = (state == HEAT);
  assign cooling = (state == COOL);

endmodule

// File: rtl/smart_home_multizone.sv
// Multizone smart-home controller: N_ZONES independent thermostats plus a
// shared push-button RGB colour sequencer.
module smart_home_multizone
  import smart_home_pkg::*;
#(
  parameter int TEMP_W    = 5,
  parameter int N_ZONES   = 2,
  parameter int HEAT_ON   = 18,
  parameter int HEAT_OFF  = 20,
  parameter int COOL_ON   = 22,
  parameter int COOL_OFF  = 20,
  parameter int MIN_DWELL = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      button,
  input  logic [N_ZONES*TEMP_W-1:0] temperature,
  input  logic [N_ZONES-1:0]        zone_en,
  output logic [N_ZONES-1:0]        heating,
  output logic [N_ZONES-1:0]        cooling,
  output logic [2:0]                colour
);

  if (!(N_ZONES >= 1 && MIN_DWELL >= 1 &&
        HEAT_ON < HEAT_OFF && HEAT_OFF <= COOL_OFF &&
        COOL_OFF < COOL_ON && COOL_ON < (2 ** TEMP_W))) begin : g_param_check
    $error("smart_home_multizone: illegal threshold/parameter set");
  end

  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    zone_thermostat #(
      .TEMP_W    (TEMP_W),
      .HEAT_ON   (HEAT_ON),
      .HEAT_OFF  (HEAT_OFF),
      .COOL_ON   (COOL_ON),
      .COOL_OFF  (COOL_OFF),
      .MIN_DWELL (MIN_DWELL)
    ) u_zone (
      .clk     (clk),
      .rst     (rst),
      .en      (zone_en[z]),
      .temp    (temperature[z*TEMP_W +: TEMP_W]),
      .heating (heating[z]),
      .cooling (cooling[z])
    );
  end

  logic button_q;

  // One colour step per press, no matter how long the button is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      button_q <= 1'b0;
      colour   <= 3'b000;
    end else begin
      button_q <= button;
      if (button && !button_q)
        colour <= next_colour(colour);
    end
  end

endmodule

// File: tb/tb_smart_home_multizone.sv
// Directed bench for smart_home_multizone with hand-computed expectations.
module tb_smart_home_multizone;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [4:0] t0, t1;
  logic [9:0] temperature;
  logic [1:0] zone_en;
  logic [1:0] heating, cooling;
  logic [2:0] colour;

  int checks = 0;
  int errors = 0;

  assign temperature = {t1, t0};

  always #5 clk = ~clk;

  smart_home_multizone dut (
    .clk         (clk),
    .rst         (rst),
    .button      (button),
    .temperature (temperature),
    .zone_en     (zone_en),
    .heating     (heating),
    .cooling     (cooling),
    .colour      (colour)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; button = 1'b0; t0 = 5'd20; t1 = 5'd20; zone_en = 2'b11;
    #1;
    rst = 1'b0;
    t0 = 5'($urandom); t1 = 5'($urandom);
    button = 1'($urandom); zone_en = 2'($urandom);
    #1;
    checks++;
    if (heating !== 2'b00 || cooling !== 2'b00 || colour !== 3'b000) begin
      errors++;
      $display("FAIL reset_async: heat=%b cool=%b colour=%b want 00 00 000", heating, cooling, colour);
    end
    tick(); tick();
    button = 1'b0; t0 = 5'd20; t1 = 5'd20; zone_en = 2'b11;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (heating !== 2'b00 || cooling !== 2'b00 || colour !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: heat=%b cool=%b colour=%b want 00 00 000", heating, cooling, colour);
    end
  endtask

  task automatic test_heat();
    t0 = 5'd17;
    tick();
    checks++;
    if (heating !== 2'b01) begin
      errors++;
      $display("FAIL heat_enter: heat=%b want 01", heating);
    end
    t0 = 5'd21;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (heating !== 2'b01 || cooling !== 2'b00) begin
        errors++;
        $display("FAIL heat_dwell_%0d: heat=%b cool=%b want 01 00", i, heating, cooling);
      end
    end
    tick();
    checks++;
    if (heating !== 2'b00 || cooling !== 2'b00) begin
      errors++;
      $display("FAIL heat_exit: heat=%b cool=%b want 00 00", heating, cooling);
    end
    t0 = 5'd20;
  endtask

  task automatic test_cool();
    t1 = 5'd23;
    tick();
    checks++;
    if (cooling !== 2'b10) begin
      errors++;
      $display("FAIL cool_enter: cool=%b want 10", cooling);
    end
    t1 = 5'd21;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (cooling !== 2'b10) begin
        errors++;
        $display("FAIL cool_hold_%0d: cool=%b want 10", i, cooling);
      end
    end
    t1 = 5'd20;
    tick();
    checks++;
    if (cooling !== 2'b00) begin
      errors++;
      $display("FAIL cool_exit: cool=%b want 00", cooling);
    end
    // Cool -> heat reversal must pass through a visible idle cycle.
    t1 = 5'd23;
    tick();
    checks++;
    if (cooling !== 2'b10) begin
      errors++;
      $display("FAIL rev_cool_enter: cool=%b want 10", cooling);
    end
    t1 = 5'd17;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (cooling !== 2'b10 || heating !== 2'b00) begin
        errors++;
        $display("FAIL rev_hold_%0d: cool=%b heat=%b want 10 00", i, cooling, heating);
      end
    end
    tick();
    checks++;
    if (cooling !== 2'b00 || heating !== 2'b00) begin
      errors++;
      $display("FAIL rev_idle: cool=%b heat=%b want 00 00", cooling, heating);
    end
    tick();
    checks++;
    if (heating !== 2'b10 || cooling !== 2'b00) begin
      errors++;
      $display("FAIL rev_heat: heat=%b cool=%b want 10 00", heating, cooling);
    end
    t1 = 5'd20;
    repeat (8) tick();
    checks++;
    if (heating !== 2'b00) begin
      errors++;
      $display("FAIL rev_settle: heat=%b want 00", heating);
    end
  endtask

  task automatic test_colour();
    logic [2:0] exp_seq [6];
    exp_seq = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001};
    button = 1'b1;
    tick();
    checks++;
    if (colour !== 3'b001) begin
      errors++;
      $display("FAIL colour_first: colour=%b want 001", colour);
    end
    repeat (9) tick();
    checks++;
    if (colour !== 3'b001) begin
      errors++;
      $display("FAIL colour_held: colour=%b want 001", colour);
    end
    button = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      button = 1'b1;
      tick();
      button = 1'b0;
      tick();
      checks++;
      if (colour !== exp_seq[i]) begin
        errors++;
        $display("FAIL colour_step_%0d: colour=%b want %b", i, colour, exp_seq[i]);
      end
    end
  endtask

  task automatic test_zone_en();
    t0 = 5'd17; t1 = 5'd17;
    tick();
    tick();
    checks++;
    if (heating !== 2'b11) begin
      errors++;
      $display("FAIL en_both_heat: heat=%b want 11", heating);
    end
    zone_en = 2'b01;
    tick();
    checks++;
    if (heating !== 2'b01 || cooling !== 2'b00) begin
      errors++;
      $display("FAIL en_override: heat=%b cool=%b want 01 00", heating, cooling);
    end
    tick();
    checks++;
    if (heating !== 2'b01) begin
      errors++;
      $display("FAIL en_forced_idle: heat=%b want 01", heating);
    end
    t0 = 5'd20; t1 = 5'd20; zone_en = 2'b11;
    repeat (8) tick();
    checks++;
    if (heating !== 2'b00 || cooling !== 2'b00) begin
      errors++;
      $display("FAIL en_settle: heat=%b cool=%b want 00 00", heating, cooling);
    end
  endtask

  task automatic test_reset_mid();
    t1 = 5'd23;
    tick();
    tick();
    checks++;
    if (cooling !== 2'b10 || colour !== 3'b001) begin
      errors++;
      $display("FAIL mid_pre: cool=%b colour=%b want 10 001", cooling, colour);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (cooling !== 2'b00 || heating !== 2'b00 || colour !== 3'b000) begin
      errors++;
      $display("FAIL mid_async: cool=%b heat=%b colour=%b want 00 00 000", cooling, heating, colour);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cooling !== 2'b00) begin
      errors++;
      $display("FAIL mid_release: cool=%b want 00", cooling);
    end
    tick();
    checks++;
    if (cooling !== 2'b10) begin
      errors++;
      $display("FAIL mid_reenter: cool=%b want 10", cooling);
    end
    t1 = 5'd20;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (cooling !== 2'b10) begin
        errors++;
        $display("FAIL mid_dwell_%0d: cool=%b want 10", i, cooling);
      end
    end
    tick();
    checks++;
    if (cooling !== 2'b00) begin
      errors++;
      $display("FAIL mid_exit: cool=%b want 00", cooling);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_heat();
    test_cool();
    test_colour();
    test_zone_en();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
